// File: rtl/display_arbiter.sv
// Round-robin owner arbitration for the shared seven-segment display path, with a minimum hold.
// Optional build macro DISPLAY_ARB_PREEMPT_EN: requester 0 may cut a running hold short.
module display_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 200_000_000,
  parameter int unsigned DATA_W      = 48
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_opcode,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         data_out,
  output logic [1:0]                opcode_out,
  output logic                      busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          opcode_q, opcode_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic                capture;
  logic [PTR_W-1:0]    cap_idx;
  int unsigned         cand;

  // Winner search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    data_d     = data_q;
    opcode_d   = opcode_q;
    busy_d     = busy_q;
    capture    = 1'b0;
    cap_idx    = win_idx;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) capture = 1'b1;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (win_found) begin
            capture = 1'b1;
          end else begin
            // Display keeps showing the last value after the owner is released.
            state_d    = ST_IDLE;
            grant_d    = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
`ifdef DISPLAY_ARB_PREEMPT_EN
          if (req[0] && !grant_q[0]) begin
            capture = 1'b1;
            cap_idx = '0;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      rr_ptr_d   = cap_idx;
      grant_d    = NUM_REQ'(1) << cap_idx;
      ack_d      = NUM_REQ'(1) << cap_idx;
      data_d     = req_data[32'(cap_idx)*DATA_W +: DATA_W];
      opcode_d   = req_opcode[32'(cap_idx)*2 +: 2];
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= PTR_RST;
      grant_q    <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      opcode_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      opcode_q   <= opcode_d;
      busy_q     <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign data_out   = data_q;
  assign opcode_out = opcode_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter (NUM_REQ=4, HOLD_CYCLES=4): directed scenarios plus random traffic.
module tb_display_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 4;
  localparam int unsigned DW   = 48;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N*2-1:0]  req_opcode;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic [DW-1:0]   data_out;
  logic [1:0]      opcode_out;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N-1:0]  onehot;
    logic [DW-1:0] data;
    logic [1:0]    op;
  } cap_t;

  cap_t sb_q[$];
  int   ack_log[$];
  cap_t sb_e;

  // Reference model: owner index (-1 when idle), cycles elapsed in current hold, last owner.
  int            m_owner   = -1;
  int            m_elapsed = 0;
  int            m_last    = N - 1;
  int            m_cap;
  int            m_c;
  logic [N-1:0]  exp_grant = '0;
  logic [N-1:0]  exp_ack   = '0;
  logic [DW-1:0] exp_data  = '0;
  logic [1:0]    exp_op    = '0;
  logic          exp_busy  = 1'b0;

  int busy_cnt;
  int idle_cnt;
  int t3_exp[5] = '{0, 1, 2, 3, 0};
  int t4_exp[3] = '{1, 3, 1};

  always #5 clk = ~clk;

  display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .req_opcode (req_opcode),
    .ack        (ack),
    .grant      (grant),
    .data_out   (data_out),
    .opcode_out (opcode_out),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_owner = -1; m_elapsed = 0; m_last = N - 1;
        exp_grant = '0; exp_ack = '0; exp_data = '0; exp_op = '0; exp_busy = 1'b0;
        sb_q.delete();
      end else begin
        m_cap = -1;
        if (m_owner < 0 || m_elapsed == HOLD - 1) begin
          for (int k = 1; k <= N; k++) begin
            m_c = (m_last + k) % N;
            if (m_cap < 0 && req[m_c]) m_cap = m_c;
          end
          if (m_cap < 0) m_owner = -1;
        end else begin
          m_elapsed++;
`ifdef DISPLAY_ARB_PREEMPT_EN
          if (req[0] && m_owner != 0) m_cap = 0;
`endif
        end
        exp_ack = '0;
        if (m_cap >= 0) begin
          m_owner        = m_cap;
          m_last         = m_cap;
          m_elapsed      = 0;
          exp_ack[m_cap] = 1'b1;
          exp_data       = req_data[m_cap*DW +: DW];
          exp_op         = req_opcode[m_cap*2 +: 2];
          sb_q.push_back('{onehot: exp_ack, data: exp_data, op: exp_op});
        end
        exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        exp_busy  = (m_owner >= 0);
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on every ack.
  initial begin
    forever begin
      @(negedge clk);
      check("grant", 64'(grant), 64'(exp_grant));
      check("busy", 64'(busy), 64'(exp_busy));
      check("ack", 64'(ack), 64'(exp_ack));
      check("data_out", 64'(data_out), 64'(exp_data));
      check("opcode_out", 64'(opcode_out), 64'(exp_op));
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_ack: got ack %b with no capture expected at %0t", ack, $time);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_ack", 64'(ack), 64'(sb_e.onehot));
          check("sb_data", 64'(data_out), 64'(sb_e.data));
          check("sb_op", 64'(opcode_out), 64'(sb_e.op));
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_data = '0; req_opcode = '0;
    repeat (3) @(negedge clk);
    check("reset_grant", 64'(grant), 64'(0));
    check("reset_data", 64'(data_out), 64'(0));
    reset_n = 1'b1;

    // Single request capture and minimum hold, value retained afterwards.
    @(negedge clk);
    req = 4'b0100;
    req_data[2*DW +: DW] = 48'h123456789ABC;
    req_opcode[2*2 +: 2] = 2'b01;
    @(posedge clk); #1;
    check("t2_ack", 64'(ack), 64'(4'b0100));
    check("t2_grant", 64'(grant), 64'(4'b0100));
    check("t2_data", 64'(data_out), 64'h123456789ABC);
    check("t2_op", 64'(opcode_out), 64'(2'b01));
    check("t2_busy", 64'(busy), 64'(1));
    @(negedge clk);
    req = '0;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t2_busy_cycles", 64'(busy_cnt), 64'(4));
    check("t2_idle_grant", 64'(grant), 64'(0));
    check("t2_idle_busy", 64'(busy), 64'(0));
    check("t2_data_kept", 64'(data_out), 64'h123456789ABC);

    // Asynchronous reset in the middle of a hold.
    @(negedge clk);
    req = 4'b0010;
    req_data[1*DW +: DW] = 48'hCAFE_0000_BEEF;
    req_opcode[1*2 +: 2] = 2'b10;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t1_grant", 64'(grant), 64'(0));
    check("t1_ack", 64'(ack), 64'(0));
    check("t1_data", 64'(data_out), 64'(0));
    check("t1_op", 64'(opcode_out), 64'(0));
    check("t1_busy", 64'(busy), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // All requesters continuously requesting: rotation 0,1,2,3,0 with no idle gap.
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = 48'(64'h1111_0000_0000 * (i + 1));
      req_opcode[i*2 +: 2] = 2'(i);
    end
    ack_log.delete();
    @(negedge clk);
    req = 4'b1111;
    idle_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = 1'b1;
      end
    end
    req = '0;
    check("t3_no_gap", 64'(idle_cnt), 64'(0));
    check("t3_count", 64'(ack_log.size() >= 5), 64'(1));
    for (int k = 0; k < 5; k++)
      if (k < ack_log.size()) check("t3_order", 64'(ack_log[k]), 64'(t3_exp[k]));
    run_cycles(8);

    // Owner 1 re-requests during its hold while requester 3 waits.
    ack_log.delete();
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1010;
    run_cycles(14);
    check("t4_count", 64'(ack_log.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      if (k < ack_log.size()) check("t4_order", 64'(ack_log[k]), 64'(t4_exp[k]));

    // Requester 2 pulses mid-hold and withdraws before arbitration.
    ack_log.delete();
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    run_cycles(8);
    check("t5_count", 64'(ack_log.size()), 64'(1));
    if (ack_log.size() > 0) check("t5_owner", 64'(ack_log[0]), 64'(3));

    // Requester 0 arrives while owner 2 is one cycle into its hold.
    ack_log.delete();
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
`ifdef DISPLAY_ARB_PREEMPT_EN
    check("t6_grant", 64'(grant), 64'(4'b0001));
`else
    check("t6_grant", 64'(grant), 64'(4'b0100));
`endif
    for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    run_cycles(8);
    check("t6_count", 64'(ack_log.size()), 64'(2));
    if (ack_log.size() > 1) check("t6_second", 64'(ack_log[1]), 64'(0));

    // Random traffic: withdrawals, re-requests after ack, fresh data each request.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 29) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = 48'({$urandom, $urandom});
          req_opcode[i*2 +: 2] = 2'($urandom);
        end
      end
    end
    req = '0;
    run_cycles(10);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("final_idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
